// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding,
// default parameter values and a small constant helper.
package rst_seq_pkg;

  localparam int DEF_N_STAGES    = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } seq_state_e;

  // Larger of two integers, used to size the shared hold/gap counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sequencer_chk.sv
// Property checker for the reset sequencer outputs: released bits only ever
// clear all together, and rst_done never shows with a domain still in reset.
module rst_sequencer_chk #(
  parameter int N_STAGES = 3
) (
  input logic                clk,
  input logic                rst_n,
  input logic [N_STAGES-1:0] rst_n_out,
  input logic                rst_done
);

  for (genvar k = 0; k < N_STAGES; k++) begin : g_mono
    a_monotonic : assert property (@(posedge clk) disable iff (!rst_n)
      ($past(rst_n_out[k]) && !rst_n_out[k]) |-> (rst_n_out == '0));
  end

  a_done_all_released : assert property (@(posedge clk) disable iff (!rst_n)
    rst_done |-> (&rst_n_out));

endmodule

// File: rtl/rst_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchronizer.
// sync_rst_n is the synchronized reset; sync_rst_n_next is the value it will
// take on the coming edge, letting the sequencer act on the very edge where
// the synchronized reset rises.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n,
  output logic sync_rst_n_next
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift a constant one through the chain; rst_n clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n      = chain_r[SYNC_STAGES-1];
  assign sync_rst_n_next = chain_r[SYNC_STAGES-2];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: after the synchronized reset releases, hold every
// downstream domain in reset for HOLD_CYCLES, then release the domains one
// at a time, GAP_CYCLES apart. A software request restarts the hold phase.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sw_rst_req,
  output logic [N_STAGES-1:0]             rst_n_out,
  output logic [$clog2(N_STAGES+1)-1:0]   rst_stage,
  output logic                            rst_done
);

  localparam int CNT_W   = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int STAGE_W = $clog2(N_STAGES + 1);

  logic                sync_rst_n;
  logic                sync_rst_n_next;

  seq_state_e          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [N_STAGES-1:0] out_r, out_s;
  logic [STAGE_W-1:0]  stage_r, stage_s;
  logic                done_r, done_s;
  logic [N_STAGES-1:0] stage_mask_s;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk             (clk),
    .rst_n           (rst_n),
    .sync_rst_n      (sync_rst_n),
    .sync_rst_n_next (sync_rst_n_next)
  );

  // One-hot mask selecting the next domain to release.
  always_comb begin
    stage_mask_s = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      stage_mask_s[k] = (stage_r == STAGE_W'(k));
    end
  end

  // Next-state logic; a software request outranks everything except WAIT_SYNC.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    out_s   = out_r;
    stage_s = stage_r;
    done_s  = 1'b0;
    if (sw_rst_req && (state_r != WAIT_SYNC)) begin
      state_s = HOLD;
      cnt_s   = '0;
      out_s   = '0;
      stage_s = '0;
    end else begin
      case (state_r)
        WAIT_SYNC: begin
          if (sync_rst_n_next) begin
            state_s = HOLD;
            cnt_s   = '0;
          end else begin
            state_s = WAIT_SYNC;
          end
        end
        HOLD: begin
          if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
            out_s   = out_r | stage_mask_s;
            stage_s = STAGE_W'(1);
            cnt_s   = '0;
            state_s = (N_STAGES == 1) ? DONE : RELEASE;
          end else if (sync_rst_n) begin
            cnt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
        RELEASE: begin
          if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
            out_s   = out_r | stage_mask_s;
            stage_s = stage_r + STAGE_W'(1);
            cnt_s   = '0;
            if (stage_r == STAGE_W'(N_STAGES - 1)) begin
              state_s = DONE;
            end else begin
              state_s = RELEASE;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          done_s = 1'b1;
        end
        default: begin
          state_s = WAIT_SYNC;
          cnt_s   = '0;
          out_s   = '0;
          stage_s = '0;
        end
      endcase
    end
  end

  // State and output registers, all cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_SYNC;
      cnt_r   <= '0;
      out_r   <= '0;
      stage_r <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      stage_r <= stage_s;
      done_r  <= done_s;
    end
  end

  assign rst_n_out = out_r;
  assign rst_stage = stage_r;
  assign rst_done  = done_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer with default parameters. Expected
// outputs per edge come from a closed-form timing model and go through a
// scoreboard queue before being compared with the DUT.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int SW   = $clog2(N + 1);

  typedef struct packed {
    logic [N-1:0]  out;
    logic [SW-1:0] stage;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic [N-1:0]  rst_n_out;
  logic [SW-1:0] rst_stage;
  logic          rst_done;

  int   n_checks = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  rst_sequencer #(
    .N_STAGES    (N),
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (rst_n_out),
    .rst_stage  (rst_stage),
    .rst_done   (rst_done)
  );

  rst_sequencer_chk #(.N_STAGES(N)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_n_out (rst_n_out),
    .rst_done  (rst_done)
  );

  // Expected outputs after edge e when the hold phase began at edge r.
  function automatic obs_t model(input int e, input int r);
    obs_t o;
    o = '0;
    for (int k = 0; k < N; k++) begin
      if (e >= r + HOLD + k * GAP) begin
        o.out[k] = 1'b1;
        o.stage  = SW'(k + 1);
      end
    end
    if (e >= r + HOLD + (N - 1) * GAP + 1) o.done = 1'b1;
    return o;
  endfunction

  function automatic obs_t observed();
    return {rst_n_out, rst_stage, rst_done};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("out=%b stage=%0d done=%b", o.out, o.stage, o.done);
  endfunction

  // Pulse rst_n low across two edges; the next rising edge is edge 1.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sw_rst_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    #3;
    got = observed();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_async: got %s, expected all zero", fmt(got));
    end
    repeat (3) @(posedge clk);
    #1;
    got = observed();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_held: got %s, expected all zero", fmt(got));
    end
  endtask

  task automatic test_power_on();
    obs_t got, exp;
    int   r;
    apply_reset();
    r = SYNC;
    for (int e = 1; e <= 30; e++) begin
      sw_rst_req = 1'b0;
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL power_on edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_sw_in_wait_sync();
    obs_t got, exp;
    int   r;
    apply_reset();
    r = SYNC;
    for (int e = 1; e <= 30; e++) begin
      sw_rst_req = (e == 1);
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sw_wait_sync edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_async_mid_release();
    obs_t got, exp;
    int   r;
    apply_reset();
    r = SYNC;
    for (int e = 1; e <= 23; e++) begin
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mid_release edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = observed();
    n_checks++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL mid_release_async: got %s, expected all zero", fmt(got));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL re_release edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_sw_pulse();
    obs_t got, exp;
    int   r;
    apply_reset();
    r = SYNC;
    for (int e = 1; e <= 68; e++) begin
      sw_rst_req = (e == 40);
      if (sw_rst_req && e > SYNC) r = e;
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sw_pulse edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_sw_held();
    obs_t got, exp;
    int   r;
    apply_reset();
    r = SYNC;
    for (int e = 1; e <= 76; e++) begin
      sw_rst_req = (e >= 40 && e <= 49);
      if (sw_rst_req && e > SYNC) r = e;
      exp_q.push_back(model(e, r));
      @(posedge clk);
      #1;
      got = observed();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sw_held edge %0d: got %s, expected %s", e, fmt(got), fmt(exp));
      end
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_in_wait_sync();
    test_async_mid_release();
    test_sw_pulse();
    test_sw_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter N_STAGES, default 3: number of downstream reset domains; SHALL be >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth; SHALL be >= 2.
REQ-003 Parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted after the synchronized reset releases; SHALL be >= 1.
REQ-004 Parameter GAP_CYCLES, default 4: cycles between successive stage releases; SHALL be >= 1.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port sw_rst_req  input  1  synchronous software reset request, sampled each rising edge.
REQ-008 Port rst_n_out  output  N_STAGES  per-domain active-low reset; bit k is released k-th.
REQ-009 Port rst_stage  output  $clog2(N_STAGES+1)  count of released stages, 0..N_STAGES.
REQ-010 Port rst_done  output  1  high when all stages are released.
REQ-011 The block SHALL have one clock and an asynchronous active-low reset; named clk and rst_n.

Function
REQ-012 rst_n low SHALL immediately (asynchronously) drive rst_n_out to all-zero, rst_stage to 0, rst_done to 0, FSM to WAIT_SYNC.
REQ-013 An internal synchronized reset SHALL rise SYNC_STAGES rising edges after rst_n deasserts (async assert, sync deassert).
REQ-014 FSM states SHALL be WAIT_SYNC, HOLD, RELEASE, DONE.
REQ-015 WAIT_SYNC -> HOLD on the first edge the synchronized reset is high; the hold counter clears to 0 on entry.
REQ-016 HOLD SHALL count HOLD_CYCLES edges with all outputs low, then set rst_n_out[0], rst_stage=1, and enter RELEASE (or DONE if N_STAGES=1).
REQ-017 RELEASE SHALL count GAP_CYCLES edges, then set rst_n_out[rst_stage], increment rst_stage; after the last bit, enter DONE.
REQ-018 rst_done SHALL rise on the edge after rst_n_out[N_STAGES-1] rises, and stay high only in DONE.
REQ-019 With rst_n high before edge 1, rst_n_out[k] SHALL rise at edge SYNC_STAGES+HOLD_CYCLES+k*GAP_CYCLES.
REQ-020 sw_rst_req high in HOLD, RELEASE or DONE at edge e SHALL, at edge e, clear all outputs and counter and enter HOLD; rst_n_out[0] then rises at edge e+HOLD_CYCLES.
REQ-021 sw_rst_req in WAIT_SYNC SHALL be ignored.
REQ-022 sw_rst_req held high SHALL keep the block in HOLD with counter at 0 (no release).
REQ-023 Released bits SHALL be monotonic: once set, bit k clears only via rst_n or sw_rst_req, and always with all other bits.
REQ-024 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-025 rst_n SHALL appear only as an asynchronous clear, never as a data operand; the counter SHALL be $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits and never wrap.

Reset
REQ-026 Every flop SHALL have asynchronous clear on rst_n low; synchronizer flops reset to 0 with D tied to 1.
REQ-027 Reset mid-operation (any state) SHALL take effect without a clock edge and restart the full sequence of REQ-019.

Structure
REQ-028 Package rst_seq_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-029 Sub-module rst_sync (SYNC_STAGES-deep async-assert/sync-deassert synchronizer) SHALL produce the internal synchronized reset.

Verification (defaults N=3, SYNC=2, HOLD=16, GAP=4)
REQ-030 Release rst_n before edge 1 -> rst_n_out 3'b001 at edge 18, 3'b011 at 22, 3'b111 at 26; rst_done at 27; rst_stage 1/2/3.
REQ-031 rst_n low mid-RELEASE (rst_n_out=3'b011), no clock -> outputs 0 immediately; re-release repeats REQ-030 timing.
REQ-032 sw_rst_req 1-cycle pulse at edge 40 in DONE -> outputs 0 at edge 40; 3'b001 at 56, 3'b111 at 64, rst_done at 65.
REQ-033 sw_rst_req held high edges 40..49 -> outputs stay 0 through edge 49; rst_n_out[0] rises at edge 65.
REQ-034 sw_rst_req pulse at edge 1 (WAIT_SYNC) -> ignored; REQ-030 timing unchanged.
REQ-035 Assertions throughout: rst_n_out bits monotonic per REQ-023; rst_done implies rst_n_out all-ones.
